// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and frame geometry for the I2S transmit frame controller
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // One frame carries a left and a right word, one bit per sclk cycle.
    function automatic int frame_len(input int pdata_width);
        return 2 * pdata_width;
    endfunction

endpackage

// File: rtl/i2s_frame_counter.sv
// rtl/i2s_frame_counter.sv - bit position counter, registered LRCK and end-of-frame strobe
module i2s_frame_counter
    import i2s_pkg::*;
#(
    parameter int  PDATA_WIDTH = 32,
    localparam int BW          = $clog2(frame_len(PDATA_WIDTH))
) (
    input  logic          sclk_in,
    input  logic          rst,
    input  logic          run,
    output logic [BW-1:0] bit_cnt,
    output logic          lrck_out,
    output logic          wrap
);

    localparam int FRAME_LEN = frame_len(PDATA_WIDTH);

    logic [BW-1:0] cnt_nxt;

    assign wrap = (bit_cnt == BW'(FRAME_LEN - 1));

    always_comb begin
        cnt_nxt = '0;
        if (run && !wrap)
            cnt_nxt = bit_cnt + BW'(1);
    end

    // LRCK is decoded from the next count so it lines up with bit_cnt in the same cycle.
    always_ff @(posedge sclk_in) begin
        if (rst) begin
            bit_cnt  <= '0;
            lrck_out <= 1'b0;
        end else begin
            bit_cnt  <= cnt_nxt;
            lrck_out <= (cnt_nxt >= BW'(PDATA_WIDTH));
        end
    end

endmodule

// File: rtl/i2s_tx_frame_ctrl.sv
// rtl/i2s_tx_frame_ctrl.sv - frame scheduler feeding held stereo words to the I2S serializer
module i2s_tx_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int PDATA_WIDTH     = 32,
    parameter bit UNDERRUN_REPEAT = 1'b0,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                   sclk_in,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PDATA_WIDTH-1:0] s_ldata,
    input  logic [PDATA_WIDTH-1:0] s_rdata,
    output logic                   lrck_out,
    output logic [PDATA_WIDTH-1:0] pldata_out,
    output logic [PDATA_WIDTH-1:0] prdata_out,
    output logic                   frame_start,
    output logic                   busy,
    output logic                   underrun_flag,
    output logic [CNT_WIDTH-1:0]   underrun_cnt,
    input  logic                   underrun_clr
);

    localparam int BW = $clog2(frame_len(PDATA_WIDTH));

    state_t        state;
    logic [BW-1:0] bit_cnt;
    logic          wrap;
    logic          underrun;

    i2s_frame_counter #(
        .PDATA_WIDTH(PDATA_WIDTH)
    ) u_frame_counter (
        .sclk_in (sclk_in),
        .rst     (rst),
        .run     (state == ST_RUN),
        .bit_cnt (bit_cnt),
        .lrck_out(lrck_out),
        .wrap    (wrap)
    );

    // Ready never looks at s_valid, so the source may wait on it without a loop.
    assign s_ready     = en && ((state == ST_PRIME) || ((state == ST_RUN) && wrap));
    assign underrun    = (state == ST_RUN) && wrap && en && !s_valid;
    assign busy        = (state != ST_IDLE);
    assign frame_start = (state == ST_RUN) && (bit_cnt == '0);

    always_ff @(posedge sclk_in) begin
        if (rst) begin
            state         <= ST_IDLE;
            pldata_out    <= '0;
            prdata_out    <= '0;
            underrun_flag <= 1'b0;
            underrun_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en)
                        state <= ST_PRIME;
                end
                ST_PRIME: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (s_valid) begin
                        pldata_out <= s_ldata;
                        prdata_out <= s_rdata;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wrap) begin
                        if (!en) begin
                            state      <= ST_IDLE;
                            pldata_out <= '0;
                            prdata_out <= '0;
                        end else if (s_valid) begin
                            pldata_out <= s_ldata;
                            prdata_out <= s_rdata;
                        end else if (!UNDERRUN_REPEAT) begin
                            pldata_out <= '0;
                            prdata_out <= '0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A fresh underrun outranks a clear landing on the same edge.
            if (underrun) begin
                underrun_flag <= 1'b1;
                if (underrun_clr)
                    underrun_cnt <= CNT_WIDTH'(1);
                else if (!(&underrun_cnt))
                    underrun_cnt <= underrun_cnt + CNT_WIDTH'(1);
            end else if (underrun_clr) begin
                underrun_flag <= 1'b0;
                underrun_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_frame_ctrl.sv
// tb/tb_i2s_tx_frame_ctrl.sv - self-checking bench for i2s_tx_frame_ctrl (zero-fill and repeat variants)
module tb_i2s_tx_frame_ctrl;

    localparam int W  = 32;
    localparam int FL = 2 * W;

    logic          sclk_in = 1'b0;
    logic          rst, en, s_valid, underrun_clr;
    logic [W-1:0]  s_ldata, s_rdata;

    logic          s_ready0, lrck0, fs0, busy0, flag0;
    logic [W-1:0]  pl0, pr0;
    logic [15:0]   cnt0;
    logic          s_ready1, lrck1, fs1, busy1, flag1;
    logic [W-1:0]  pl1, pr1;
    logic [1:0]    cnt1;

    int checks = 0;
    int errors = 0;

    always #5 sclk_in = ~sclk_in;

    i2s_tx_frame_ctrl #(.PDATA_WIDTH(W), .UNDERRUN_REPEAT(1'b0), .CNT_WIDTH(16)) dut0 (
        .sclk_in(sclk_in), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready0),
        .s_ldata(s_ldata), .s_rdata(s_rdata), .lrck_out(lrck0), .pldata_out(pl0),
        .prdata_out(pr0), .frame_start(fs0), .busy(busy0), .underrun_flag(flag0),
        .underrun_cnt(cnt0), .underrun_clr(underrun_clr)
    );

    i2s_tx_frame_ctrl #(.PDATA_WIDTH(W), .UNDERRUN_REPEAT(1'b1), .CNT_WIDTH(2)) dut1 (
        .sclk_in(sclk_in), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready1),
        .s_ldata(s_ldata), .s_rdata(s_rdata), .lrck_out(lrck1), .pldata_out(pl1),
        .prdata_out(pr1), .frame_start(fs1), .busy(busy1), .underrun_flag(flag1),
        .underrun_cnt(cnt1), .underrun_clr(underrun_clr)
    );

    // Model: mode 0 idle, 1 waiting for first pair, 2 running; pos is the bit position in the frame.
    int           m_mode [2];
    int           m_pos  [2];
    int           m_flag [2];
    int           m_cnt  [2];
    logic [W-1:0] m_l    [2];
    logic [W-1:0] m_r    [2];
    bit           m_take;
    int           rep    [2] = '{0, 1};
    int           cmax   [2] = '{65535, 3};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge sclk_in) begin
        m_take = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit rdy;
            bit und;
            rdy = en && (m_mode[i] == 1 || (m_mode[i] == 2 && m_pos[i] == FL - 1));
            und = 1'b0;
            if (rst) begin
                m_mode[i] = 0; m_pos[i] = 0; m_flag[i] = 0; m_cnt[i] = 0;
                m_l[i] = '0;   m_r[i] = '0;
            end else begin
                if (i == 0) m_take = rdy && s_valid;
                if (m_mode[i] == 0) begin
                    if (en) m_mode[i] = 1;
                end else if (m_mode[i] == 1) begin
                    if (!en) m_mode[i] = 0;
                    else if (s_valid) begin
                        m_l[i] = s_ldata; m_r[i] = s_rdata; m_mode[i] = 2; m_pos[i] = 0;
                    end
                end else if (m_pos[i] == FL - 1) begin
                    m_pos[i] = 0;
                    if (!en) begin
                        m_mode[i] = 0; m_l[i] = '0; m_r[i] = '0;
                    end else if (s_valid) begin
                        m_l[i] = s_ldata; m_r[i] = s_rdata;
                    end else begin
                        und = 1'b1;
                        if (rep[i] == 0) begin m_l[i] = '0; m_r[i] = '0; end
                    end
                end else begin
                    m_pos[i]++;
                end
                if (und) begin
                    m_flag[i] = 1;
                    m_cnt[i]  = underrun_clr ? 1 : (m_cnt[i] == cmax[i] ? cmax[i] : m_cnt[i] + 1);
                end else if (underrun_clr) begin
                    m_flag[i] = 0; m_cnt[i] = 0;
                end
            end
        end
    end

    always @(negedge sclk_in) begin
        for (int i = 0; i < 2; i++) begin
            logic a_rdy, a_lrck, a_fs, a_busy, a_flag;
            logic [W-1:0] a_pl, a_pr;
            logic [15:0]  a_cnt;
            if (i == 0) begin
                a_rdy = s_ready0; a_lrck = lrck0; a_fs = fs0; a_busy = busy0; a_flag = flag0;
                a_pl = pl0; a_pr = pr0; a_cnt = cnt0;
            end else begin
                a_rdy = s_ready1; a_lrck = lrck1; a_fs = fs1; a_busy = busy1; a_flag = flag1;
                a_pl = pl1; a_pr = pr1; a_cnt = {14'd0, cnt1};
            end
            check($sformatf("i%0d s_ready", i), a_rdy,
                  en && (m_mode[i] == 1 || (m_mode[i] == 2 && m_pos[i] == FL - 1)));
            check($sformatf("i%0d lrck", i), a_lrck, m_mode[i] == 2 && m_pos[i] >= W);
            check($sformatf("i%0d frame_start", i), a_fs, m_mode[i] == 2 && m_pos[i] == 0);
            check($sformatf("i%0d busy", i), a_busy, m_mode[i] != 0);
            check($sformatf("i%0d pldata", i), a_pl, m_l[i]);
            check($sformatf("i%0d prdata", i), a_pr, m_r[i]);
            check($sformatf("i%0d flag", i), a_flag, m_flag[i] != 0);
            check($sformatf("i%0d cnt", i), a_cnt, m_cnt[i]);
        end
    end

    bit           auto_src = 1'b0;
    int           seq = 0;
    int           ntake = 0;
    logic [W-1:0] last_l, last_r;

    task tick();
        @(posedge sclk_in);
        #1;
        if (m_take) begin
            ntake++;
            last_l = s_ldata;
            last_r = s_rdata;
            if (auto_src) begin
                seq++;
                s_ldata = 32'hA000_0000 + seq;
                s_rdata = 32'hB000_0000 + seq;
            end
        end
    endtask

    task wait_run_pos(input int p);
        int k;
        k = 0;
        while (!(m_mode[0] == 2 && m_pos[0] == p) && k < 300) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 300) begin
            errors++;
            $display("FAIL wait_pos: bit position %0d not reached, waited %0d cycles, required < 300", p, k);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
        s_ldata = '0; s_rdata = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset pldata", pl0, 32'h0);
        check("reset busy", busy0, 1'b0);

        // Test 1: first pair through PRIME, LRCK timing
        en = 1'b1; s_valid = 1'b1; s_ldata = 32'h1111_1111; s_rdata = 32'h2222_2222;
        tick();
        check("t1 prime ready", s_ready0, 1'b1);
        tick();
        check("t1 frame_start", fs0, 1'b1);
        check("t1 pldata", pl0, 32'h1111_1111);
        check("t1 prdata", pr0, 32'h2222_2222);
        repeat (31) tick();
        check("t1 lrck at 31", lrck0, 1'b0);
        tick();
        check("t1 lrck at 32", lrck0, 1'b1);

        // Test 2: continuous incrementing source
        wait_run_pos(0);
        auto_src = 1'b1; seq = 0; ntake = 0;
        s_ldata = 32'hA000_0000; s_rdata = 32'hB000_0000;
        repeat (4 * FL) tick();
        check("t2 takes", ntake, 4);
        check("t2 last left", pl0, 32'hA000_0003);
        check("t2 last right", pr1, 32'hB000_0003);

        // Test 3: single underrun, then clear
        wait_run_pos(62);
        s_valid = 1'b0;
        tick(); tick();
        s_valid = 1'b1;
        check("t3 zero fill", pl0, 32'h0);
        check("t3 repeat left", pl1, 32'hA000_0003);
        check("t3 repeat right", pr1, 32'hB000_0003);
        check("t3 flag", flag0, 1'b1);
        check("t3 cnt0", cnt0, 16'd1);
        check("t3 cnt1", cnt1, 2'd1);
        wait_run_pos(10);
        underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
        check("t3 clr flag", flag0, 1'b0);
        check("t3 clr cnt", cnt0, 16'd0);

        // Test 6: five consecutive underruns, then clear colliding with an underrun
        wait_run_pos(62);
        s_valid = 1'b0;
        repeat (2 + 4 * FL) tick();
        check("t6 cnt0 count", cnt0, 16'd5);
        check("t6 cnt1 saturate", cnt1, 2'd3);
        check("t6 flag1", flag1, 1'b1);
        wait_run_pos(63);
        underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
        check("t6 clr+underrun cnt0", cnt0, 16'd1);
        check("t6 clr+underrun cnt1", cnt1, 2'd1);
        check("t6 clr+underrun flag", flag0, 1'b1);
        s_valid = 1'b1;

        // Test 4: graceful stop mid-frame
        wait_run_pos(10);
        en = 1'b0;
        repeat (53) tick();
        check("t4 busy at 63", busy0, 1'b1);
        tick();
        check("t4 busy fell", busy0, 1'b0);
        check("t4 pldata", pl0, 32'h0);
        check("t4 lrck", lrck0, 1'b0);
        repeat (5) tick();

        // Test 5: reset mid-frame, then clean restart
        en = 1'b1;
        wait_run_pos(40);
        rst = 1'b1; tick();
        check("t5 busy", busy0, 1'b0);
        check("t5 lrck", lrck0, 1'b0);
        check("t5 pldata", pl0, 32'h0);
        check("t5 flag", flag1, 1'b0);
        rst = 1'b0;
        tick(); tick();
        check("t5 restart frame_start", fs0, 1'b1);
        check("t5 restart pldata", pl0, last_l);
        repeat (70) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
